// File: rtl/reverse_delay_line_pkg.sv
// Shared constants and helpers for the reverse (ready-path) delay line.
package rv_pkg;

   // Legal range for the number of cascaded skid stages.
   localparam int MIN_STAGES = 1;
   localparam int MAX_STAGES = 16;

   // Width needed to count from 0 up to and including 'stages'.
   function automatic int occ_width(input int stages);
      return $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/reverse_delay_line_if.sv
// Ready/valid stream bundle used on both sides of the reverse delay line.
interface reverse_delay_line_if
   import rv_pkg::*;
#(
   parameter int DATA_WIDTH = 8
);

   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;

   // Producer side: drives payload and valid, observes ready.
   modport master (output data, output valid, input ready);
   // Consumer side: observes payload and valid, drives ready.
   modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/reverse_delay_line_stage.sv
// One skid stage: registers the ready path toward the source and holds
// a single word when the sink side stalls.
module reverse_buf_stage
   import rv_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock_port,
   input  logic                  reset_port,
   input  logic                  running,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   // Full status as it will be after the coming edge; lets the parent
   // keep a registered occupancy that moves on the same edge.
   output logic                  full_nxt
);

   logic                  skid_full;
   logic [DATA_WIDTH-1:0] skid_data;
   logic                  capture;
   logic                  drain;

   // Capture/drain decisions and the output mux. Pass-through valid is also
   // qualified by in_ready so a word can never leave while the source has
   // not yet seen ready (only possible in the first cycles after reset).
   always_comb begin
      capture   = in_valid & in_ready & ~out_ready;
      drain     = skid_full & out_ready;
      full_nxt  = skid_full;
      if (capture) begin
         full_nxt = 1'b1;
      end else if (drain) begin
         full_nxt = 1'b0;
      end
      out_data  = skid_full ? skid_data : in_data;
      out_valid = skid_full | (in_valid & in_ready);
   end

   // Skid register, full flag and registered ready toward the source.
   always_ff @(posedge clock_port or negedge reset_port) begin
      if (!reset_port) begin
         skid_full <= 1'b0;
         skid_data <= '0;
         in_ready  <= 1'b0;
      end else begin
         skid_full <= full_nxt;
         in_ready  <= ~full_nxt & running;
         if (capture) begin
            skid_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/reverse_delay_line.sv
// Cascade of skid stages that breaks the combinational ready chain between
// a producer and a consumer; zero latency while empty.
module reverse_delay_line
   import rv_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int STAGES     = 5,
   parameter int OCC_WIDTH  = occ_width(STAGES)
) (
   input  logic                  clock_port,
   input  logic                  reset_port,
   reverse_delay_line_if.slave   input_port,
   reverse_delay_line_if.master  output_port,
   output logic [OCC_WIDTH-1:0]  occupancy
);

   if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
      $error("reverse_delay_line: STAGES must lie in 1..16");
   end

   logic                 running;
   logic [STAGES-1:0]    full_nxt_vec;
   logic [OCC_WIDTH-1:0] occ_nxt;

   // Each stage keeps its own link signals so the valid/ready chains are
   // separate nets rather than slices of one vector.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [DATA_WIDTH-1:0] in_data;
      logic                  in_valid;
      logic                  in_ready;
      logic [DATA_WIDTH-1:0] out_data;
      logic                  out_valid;
      logic                  out_ready;

      if (k == 0) begin : g_head
         assign in_data  = input_port.data;
         assign in_valid = input_port.valid;
      end else begin : g_link
         assign in_data  = g_stage[k-1].out_data;
         assign in_valid = g_stage[k-1].out_valid;
      end

      if (k == STAGES - 1) begin : g_tail
         assign out_ready = output_port.ready;
      end else begin : g_next
         assign out_ready = g_stage[k+1].in_ready;
      end

      reverse_buf_stage #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_stage (
         .clock_port (clock_port),
         .reset_port (reset_port),
         .running    (running),
         .in_data    (in_data),
         .in_valid   (in_valid),
         .in_ready   (in_ready),
         .out_data   (out_data),
         .out_valid  (out_valid),
         .out_ready  (out_ready),
         .full_nxt   (full_nxt_vec[k])
      );
   end

   assign input_port.ready  = g_stage[0].in_ready;
   assign output_port.data  = g_stage[STAGES-1].out_data;
   assign output_port.valid = g_stage[STAGES-1].out_valid & running;

   // Population count of the next-cycle full flags.
   always_comb begin
      occ_nxt = '0;
      for (int i = 0; i < STAGES; i++) begin
         occ_nxt = occ_nxt + OCC_WIDTH'(full_nxt_vec[i]);
      end
   end

   // Start-up flag: the line only transfers once out of reset for one edge.
   always_ff @(posedge clock_port or negedge reset_port) begin
      if (!reset_port) begin
         running <= 1'b0;
      end else begin
         running <= 1'b1;
      end
   end

   // Registered occupancy, moving on the same edge as the stage flags.
   always_ff @(posedge clock_port or negedge reset_port) begin
      if (!reset_port) begin
         occupancy <= '0;
      end else begin
         occupancy <= occ_nxt;
      end
   end

endmodule

// File: tb/tb_reverse_delay_line.sv
// Directed bench for reverse_delay_line: reset, pass-through, stall fill,
// drain order, random backpressure and mid-operation reset.
module tb_reverse_delay_line;
   import rv_pkg::*;

   localparam int DW = 8;
   localparam int ST = 5;
   localparam int OW = occ_width(ST);

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [OW-1:0] occ;
   int            compared   = 0;
   int            mismatched = 0;

   reverse_delay_line_if #(.DATA_WIDTH(DW)) in_if ();
   reverse_delay_line_if #(.DATA_WIDTH(DW)) out_if ();

   reverse_delay_line #(
      .DATA_WIDTH (DW),
      .STAGES     (ST)
   ) dut (
      .clock_port  (clk),
      .reset_port  (rst_n),
      .input_port  (in_if),
      .output_port (out_if),
      .occupancy   (occ)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          k;
      int          sent;
      int          cyc;
      logic        hold;
      logic [7:0]  exp_b;
      logic [7:0]  q[$];

      // Reset hold with a valid word waiting upstream.
      in_if.valid  = 1'b1;
      in_if.data   = 8'hAA;
      out_if.ready = 1'b1;
      rst_n        = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_vld", int'(out_if.valid), 0);
         check("rst_rdy", int'(in_if.ready), 0);
         check("rst_occ", int'(occ), 0);
      end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("rel0_rdy", int'(in_if.ready), 0);
      check("rel0_vld", int'(out_if.valid), 0);
      @(negedge clk);
      check("rel1_rdy", int'(in_if.ready), 0);
      check("rel1_vld", int'(out_if.valid), 0);
      @(negedge clk);
      check("rel2_rdy", int'(in_if.ready), 1);
      check("rel2_vld", int'(out_if.valid), 1);
      check("rel2_data", int'(out_if.data), 32'hAA);

      // Pass-through, sink always ready.
      for (int w = 1; w <= 16; w++) begin
         tick();
         in_if.valid  = 1'b1;
         in_if.data   = 8'(w);
         out_if.ready = 1'b1;
         @(negedge clk);
         check("pt_data", int'(out_if.data), w);
         check("pt_vld", int'(out_if.valid), 1);
         check("pt_rdy", int'(in_if.ready), 1);
         check("pt_occ", int'(occ), 0);
      end

      // Sink stall fill: five words absorbed, then ready drops.
      k = 0;
      for (int c = 0; c < 7; c++) begin
         tick();
         out_if.ready = 1'b0;
         in_if.valid  = 1'b1;
         in_if.data   = 8'(32'h20 + k);
         @(negedge clk);
         check("fill_occ", int'(occ), k);
         check("fill_rdy", int'(in_if.ready), (k < ST) ? 1 : 0);
         check("fill_vld", int'(out_if.valid), 1);
         check("fill_data", int'(out_if.data), 32'h20);
         if (k < ST) k++;
      end

      // Drain in order; ready returns after the source-side stage empties.
      for (int j = 0; j <= ST; j++) begin
         tick();
         in_if.valid  = 1'b0;
         out_if.ready = 1'b1;
         @(negedge clk);
         check("drain_occ", int'(occ), ST - j);
         if (j < ST) begin
            check("drain_vld", int'(out_if.valid), 1);
            check("drain_data", int'(out_if.data), 32'h20 + j);
            check("drain_rdy", int'(in_if.ready), 0);
         end else begin
            check("drain_end_vld", int'(out_if.valid), 0);
            check("drain_end_rdy", int'(in_if.ready), 1);
         end
      end

      // Random backpressure with an in-order scoreboard.
      sent = 0;
      cyc  = 0;
      hold = 1'b0;
      while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
         tick();
         if (!hold) begin
            if (sent < 1000 && $urandom_range(0, 1) == 1) begin
               in_if.valid = 1'b1;
               in_if.data  = 8'(sent * 7 + 3);
               hold        = 1'b1;
            end else begin
               in_if.valid = 1'b0;
            end
         end
         out_if.ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("rand_occ_max", int'(occ <= OW'(ST)), 1);
         if (in_if.valid && in_if.ready) begin
            q.push_back(in_if.data);
            sent++;
            hold = 1'b0;
         end
         if (out_if.valid && out_if.ready) begin
            if (q.size() == 0) begin
               check("rand_extra", int'(out_if.valid), 0);
            end else begin
               exp_b = q.pop_front();
               check("rand_order", int'(out_if.data), int'(exp_b));
            end
         end
         cyc++;
      end
      check("rand_sent", sent, 1000);
      check("rand_left", q.size(), 0);

      // Reset in the middle of operation with three words held.
      tick();
      in_if.valid  = 1'b0;
      out_if.ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         out_if.ready = 1'b0;
         in_if.valid  = 1'b1;
         in_if.data   = 8'(32'h50 + i);
         @(negedge clk);
         check("mid_fill_rdy", int'(in_if.ready), 1);
      end
      tick();
      in_if.valid = 1'b0;
      @(negedge clk);
      check("mid_occ", int'(occ), 3);
      check("mid_vld", int'(out_if.valid), 1);
      check("mid_data", int'(out_if.data), 32'h50);
      tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_vld", int'(out_if.valid), 0);
      check("mid_rst_occ", int'(occ), 0);
      check("mid_rst_rdy", int'(in_if.ready), 0);
      @(negedge clk);
      rst_n        = 1'b1;
      out_if.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge clk);
         check("restart_vld", int'(out_if.valid), 0);
         check("restart_occ", int'(occ), 0);
      end
      tick();
      in_if.valid = 1'b1;
      in_if.data  = 8'h60;
      @(negedge clk);
      check("restart_rdy", int'(in_if.ready), 1);
      check("restart_vld2", int'(out_if.valid), 1);
      check("restart_data", int'(out_if.data), 32'h60);
      tick();
      in_if.valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
